// File: rtl/gbm_multipath_engine.sv
// Multi-path geometric-Brownian-motion engine: NPATHS Euler-stepped price paths
// driven by an on-chip LFSR-based Gaussian approximation, drained over valid/ready.
module gbm_multipath_engine #(
  parameter int          W      = 18,
  parameter int          FRAC   = 14,
  parameter int          NPATHS = 4,
  parameter int          STEPW  = 16,
  parameter logic [31:0] SEED   = 32'h1ACE_B00C,
  localparam int         IW     = (NPATHS > 1) ? $clog2(NPATHS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iStart,
  input  logic [W-1:0]     iMu,
  input  logic [W-1:0]     iSigma,
  input  logic [W-1:0]     iS,
  input  logic [STEPW-1:0] iSteps,
  output logic             oBusy,
  output logic [W-1:0]     oS,
  output logic [IW-1:0]    oPath,
  output logic             oValid,
  input  logic             iReady,
  output logic             oDone,
  output logic [1:0]       oDbgState
);

  localparam int XW = 2 * W + FRAC + 8;
  localparam logic [IW-1:0]        LAST = IW'(NPATHS - 1);
  localparam logic signed [XW-1:0] ZOFF = XW'(8190);
  localparam logic signed [XW-1:0] ZMUL = XW'(7);
  localparam logic signed [XW-1:0] SMAX = {{(XW - W){1'b0}}, {W{1'b1}}};

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    path_q, path_d;
  logic [STEPW-1:0] step_q, step_d, steps_q, steps_d;
  logic [W-1:0]     mu_q, mu_d, sigma_q, sigma_d, s0_q, s0_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [W-1:0]     os_q, os_d;
  logic [IW-1:0]    opath_q, opath_d;
  logic             valid_q, valid_d, done_q, done_d;

  logic [W-1:0]     ram [NPATHS];
  logic             ram_we;
  logic [W-1:0]     ram_wdata;
  logic [IW-1:0]    rd_addr;
  logic [W-1:0]     rd_data;

  logic signed [XW-1:0] sum_s, z_s, mu_x, sig_x, s_x, prod1_s, inc_s, prod2_s, sn_s;
  logic [W-1:0]         s_sat;
  logic [31:0]          lfsr_adv;

  // Output handshake: oS/oPath are offered while oValid is high and are held
  // unchanged until a cycle with oValid & iReady, which is the transfer.
  assign oBusy     = (state_q != ST_IDLE);
  assign oS        = os_q;
  assign oPath     = opath_q;
  assign oValid    = valid_q;
  assign oDone     = done_q;
  assign oDbgState = state_q;

  // During a transfer the next path is fetched so it is presented one cycle later.
  always_comb begin
    rd_addr = path_q;
    if (state_q == ST_DRAIN && valid_q && iReady && path_q != LAST) rd_addr = path_q + IW'(1);
  end

  assign rd_data  = ram[rd_addr];
  assign lfsr_adv = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

  always_comb begin
    sum_s   = XW'(lfsr_q[11:0]) + XW'(lfsr_q[23:12]) + XW'(lfsr_q[31:20])
            + XW'({lfsr_q[7:0], lfsr_q[31:28]});
    z_s     = ((sum_s - ZOFF) * ZMUL) <<< (FRAC - 14);
    mu_x    = XW'($signed(mu_q));
    sig_x   = XW'(sigma_q);
    s_x     = XW'(rd_data);
    prod1_s = sig_x * z_s;
    inc_s   = mu_x + (prod1_s >>> FRAC);
    prod2_s = s_x * inc_s;
    sn_s    = s_x + (prod2_s >>> FRAC);
    if (sn_s[XW-1])      s_sat = '0;
    else if (sn_s > SMAX) s_sat = '1;
    else                  s_sat = sn_s[W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      path_q  <= '0;
      step_q  <= '0;
      steps_q <= '0;
      mu_q    <= '0;
      sigma_q <= '0;
      s0_q    <= '0;
      lfsr_q  <= SEED;
      os_q    <= '0;
      opath_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      path_q  <= path_d;
      step_q  <= step_d;
      steps_q <= steps_d;
      mu_q    <= mu_d;
      sigma_q <= sigma_d;
      s0_q    <= s0_d;
      lfsr_q  <= lfsr_d;
      os_q    <= os_d;
      opath_q <= opath_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we) ram[path_q] <= ram_wdata;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (iStart) state_d = ST_LOAD;
      ST_LOAD:  if (path_q == LAST) state_d = (steps_q == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (path_q == LAST && step_q == steps_q - STEPW'(1)) state_d = ST_DRAIN;
      ST_DRAIN: if (valid_q && iReady && opath_q == LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    path_d    = path_q;
    step_d    = step_q;
    steps_d   = steps_q;
    mu_d      = mu_q;
    sigma_d   = sigma_q;
    s0_d      = s0_q;
    lfsr_d    = lfsr_q;
    os_d      = os_q;
    opath_d   = opath_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = s0_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          mu_d    = iMu;
          sigma_d = iSigma;
          s0_d    = iS;
          steps_d = iSteps;
          lfsr_d  = SEED;
          path_d  = '0;
          step_d  = '0;
        end
      end
      ST_LOAD: begin
        ram_we = 1'b1;
        path_d = (path_q == LAST) ? '0 : path_q + IW'(1);
      end
      ST_RUN: begin
        ram_we    = 1'b1;
        ram_wdata = s_sat;
        lfsr_d    = lfsr_adv;
        if (path_q == LAST) begin
          path_d = '0;
          step_d = step_q + STEPW'(1);
        end else begin
          path_d = path_q + IW'(1);
        end
      end
      ST_DRAIN: begin
        if (!valid_q) begin
          os_d    = rd_data;
          opath_d = path_q;
          valid_d = 1'b1;
        end else if (iReady) begin
          if (opath_q == LAST) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            path_d  = '0;
          end else begin
            os_d    = rd_data;
            opath_d = path_q + IW'(1);
            path_d  = path_q + IW'(1);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gbm_multipath_engine.sv
// Bench for gbm_multipath_engine: directed and randomized runs checked against a
// path-by-path arithmetic model of the GBM update and its noise generator.
module tb_gbm_multipath_engine;

  localparam int          W      = 18;
  localparam int          FRAC   = 14;
  localparam int          NPATHS = 4;
  localparam int          STEPW  = 16;
  localparam logic [31:0] SEED   = 32'h1ACE_B00C;
  localparam int          IW     = 2;

  logic             CLK;
  logic             RST;
  logic             iStart;
  logic [W-1:0]     iMu, iSigma, iS;
  logic [STEPW-1:0] iSteps;
  logic             oBusy;
  logic [W-1:0]     oS;
  logic [IW-1:0]    oPath;
  logic             oValid;
  logic             iReady;
  logic             oDone;
  logic [1:0]       oDbgState;

  gbm_multipath_engine #(
    .W(W), .FRAC(FRAC), .NPATHS(NPATHS), .STEPW(STEPW), .SEED(SEED)
  ) dut (
    .CLK(CLK), .RST(RST), .iStart(iStart), .iMu(iMu), .iSigma(iSigma), .iS(iS),
    .iSteps(iSteps), .oBusy(oBusy), .oS(oS), .oPath(oPath), .oValid(oValid),
    .iReady(iReady), .oDone(oDone), .oDbgState(oDbgState)
  );

  // Clock and cycle counter
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  longint cyc_cnt = 0;
  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic logic [31:0] lfsr_next(input logic [31:0] r);
    return (r >> 1) ^ (r[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic longint gauss_z(input logic [31:0] r);
    int sum;
    sum = int'(r[11:0]) + int'(r[23:12]) + int'(r[31:20]) + int'({r[7:0], r[31:28]});
    return longint'(sum - 8190) * 7 * (longint'(1) << (FRAC - 14));
  endfunction

  task automatic model_run(input int mu, input int sigma, input int s0, input int steps);
    longint s[NPATHS];
    longint z, inc;
    longint smax;
    logic [31:0] r;
    logic [W-1:0] v;
    smax = (longint'(1) << W) - 1;
    r = SEED;
    for (int p = 0; p < NPATHS; p++) s[p] = s0;
    for (int st = 0; st < steps; st++) begin
      for (int p = 0; p < NPATHS; p++) begin
        z = gauss_z(r);
        r = lfsr_next(r);
        inc = longint'(mu) + ((longint'(sigma) * z) >>> FRAC);
        s[p] = s[p] + ((s[p] * inc) >>> FRAC);
        if (s[p] < 0) s[p] = 0;
        if (s[p] > smax) s[p] = smax;
      end
    end
    for (int p = 0; p < NPATHS; p++) begin
      v = W'(s[p]);
      exp_q.push_back(v);
    end
  endtask

  // Driver: one complete run; rdy_mode 0=always ready, 1=random, 2=5-cycle stall then toggle
  task automatic run_and_check(input string name, input int mu, input int sigma, input int s0,
                               input int steps, input int rdy_mode, input bit start_noise,
                               output logic [W-1:0] got [NPATHS]);
    longint t0;
    int xfers, k;
    bit stall_prev;
    logic [W-1:0] held_s, e;
    logic [IW-1:0] held_p;
    bit rdy;
    for (int p = 0; p < NPATHS; p++) got[p] = '0;
    model_run(mu, sigma, s0, steps);
    @(negedge CLK);
    iMu = mu[W-1:0]; iSigma = sigma[W-1:0]; iS = s0[W-1:0]; iSteps = steps[STEPW-1:0];
    iStart = 1'b1; iReady = 1'b0;
    @(negedge CLK);
    t0 = cyc_cnt;
    iStart = 1'b0;
    chk({name, "_busy"}, oBusy, 1);
    iMu = W'($urandom); iSigma = W'($urandom); iS = W'($urandom); iSteps = STEPW'($urandom);
    forever begin
      @(negedge CLK);
      if (oValid || (cyc_cnt - t0) > 4000) break;
      if (start_noise) iStart = 1'($urandom_range(0, 1));
    end
    iStart = 1'b0;
    chk({name, "_latency"}, cyc_cnt - t0, 1 + NPATHS + steps * NPATHS);
    if (!oValid) begin
      exp_q.delete();
      return;
    end
    xfers = 0; k = 0; stall_prev = 0;
    held_s = '0; held_p = '0;
    while (xfers < NPATHS && k < 200) begin
      if (stall_prev) begin
        chk({name, "_hold_s"}, oS, held_s);
        chk({name, "_hold_path"}, oPath, held_p);
      end
      chk({name, "_valid"}, oValid, 1);
      chk({name, "_path"}, oPath, xfers);
      chk({name, "_early_done"}, oDone, 0);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (k < 5) ? 1'b0 : 1'(k % 2);
      endcase
      iReady = rdy;
      if (rdy) begin
        e = exp_q.pop_front();
        chk({name, "_s"}, oS, e);
        got[xfers] = oS;
        xfers++;
        stall_prev = 0;
      end else begin
        stall_prev = 1;
        held_s = oS;
        held_p = oPath;
      end
      k++;
      @(negedge CLK);
    end
    iReady = 1'b0;
    chk({name, "_xfers"}, xfers, NPATHS);
    chk({name, "_done"}, oDone, 1);
    chk({name, "_valid_off"}, oValid, 0);
    chk({name, "_busy_off"}, oBusy, 0);
    @(negedge CLK);
    chk({name, "_done_pulse"}, oDone, 0);
    exp_q.delete();
  endtask

  logic [W-1:0] res_a [NPATHS];
  logic [W-1:0] res_b [NPATHS];
  logic [W-1:0] res_c [NPATHS];
  longint t_start;
  int rmu, rsig, rs, rst;

  initial begin
    RST = 1'b1; iStart = 1'b0; iReady = 1'b0;
    iMu = '0; iSigma = '0; iS = '0; iSteps = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", oBusy, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_done", oDone, 0);
    chk("rst_s", oS, 0);
    chk("rst_path", oPath, 0);
    RST = 1'b0;

    run_and_check("drift1", 184, 0, 24576, 1, 0, 0, res_a);
    for (int p = 0; p < NPATHS; p++) chk("drift1_lit", res_a[p], 24852);
    run_and_check("drift2", 184, 0, 24576, 2, 1, 0, res_a);
    for (int p = 0; p < NPATHS; p++) chk("drift2_lit", res_a[p], 25131);
    run_and_check("zero_steps", 184, 3408, 24576, 0, 1, 0, res_a);
    for (int p = 0; p < NPATHS; p++) chk("zero_steps_lit", res_a[p], 24576);

    run_and_check("sat_hi", 16384, 0, 200000, 1, 0, 0, res_a);
    for (int p = 0; p < NPATHS; p++) chk("sat_hi_lit", res_a[p], 262143);
    run_and_check("sat_zero", -16384, 0, 200000, 1, 0, 0, res_a);
    for (int p = 0; p < NPATHS; p++) chk("sat_zero_lit", res_a[p], 0);
    run_and_check("sat_floor", -32768, 0, 200000, 1, 0, 0, res_a);
    for (int p = 0; p < NPATHS; p++) chk("sat_floor_lit", res_a[p], 0);
    run_and_check("sat_stick", -32768, 3408, 200000, 4, 1, 0, res_a);
    for (int p = 0; p < NPATHS; p++) chk("sat_stick_lit", res_a[p], 0);

    run_and_check("backpressure", 184, 3408, 24576, 3, 2, 0, res_a);

    run_and_check("stoch_a", 184, 3408, 24576, 100, 1, 1, res_a);
    run_and_check("stoch_b", 184, 3408, 24576, 100, 2, 1, res_b);
    for (int p = 0; p < NPATHS; p++) chk("stoch_repeat", res_b[p], res_a[p]);

    // Abort a long run partway through step 50
    @(negedge CLK);
    iMu = 18'd184; iSigma = 18'd3408; iS = 18'd24576; iSteps = 16'd100;
    iStart = 1'b1;
    @(negedge CLK);
    t_start = cyc_cnt;
    iStart = 1'b0;
    while ((cyc_cnt - t_start) < (1 + NPATHS + 50 * NPATHS)) @(negedge CLK);
    chk("midrun_busy", oBusy, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", oBusy, 0);
    chk("abort_valid", oValid, 0);
    chk("abort_done", oDone, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("abort_no_done", oDone | oValid | oBusy, 0);
    end
    run_and_check("after_abort", 184, 3408, 24576, 100, 0, 0, res_c);
    for (int p = 0; p < NPATHS; p++) chk("after_abort_repeat", res_c[p], res_a[p]);

    for (int i = 0; i < 6; i++) begin
      rmu  = int'($urandom_range(0, 800)) - 400;
      rsig = int'($urandom_range(0, 6000));
      rs   = int'($urandom_range(1000, 120000));
      rst  = int'($urandom_range(0, 8));
      run_and_check("random", rmu, rsig, rs, rst, 1, 1, res_a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gbm_multipath_engine.md
Name: gbm_multipath_engine

Overview:
- Parametrised successor to the single-path risk datapath driven by iMu/iSigma/iS.
- Simulates NPATHS independent geometric-Brownian-motion price paths over iSteps time steps using the Euler update S' = S·(1 + mu + sigma·Z).
- Z is an on-chip approximately-Gaussian sample, so no external noise source is needed.
- Terminal prices stream out over a valid/ready handshake to the downstream risk/statistics stage.

Parameters:
- W, 18, bit width of prices, mu and sigma.
- FRAC, 14, fractional bits of fixed-point (Q(W-FRAC).FRAC); must be >= 14.
- NPATHS, 4, number of simulated paths (>=1, power of two not required).
- STEPW, 16, width of step-count input.
- SEED, 32'h1ACE_B00C, LFSR seed reloaded on every start; must be nonzero.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- iStart  in  1  one-cycle start pulse; sampled only in IDLE.
- iMu  in  W  drift per step, signed Q.FRAC.
- iSigma  in  W  volatility per step, unsigned Q.FRAC.
- iS  in  W  initial price, unsigned Q.FRAC.
- iSteps  in  STEPW  number of time steps.
- oBusy  out  1  high from accepted start until drain complete.
- oS  out  W  terminal price of current output path.
- oPath  out  clog2(NPATHS) (min 1)  index of path on oS.
- oValid  out  1  oS/oPath valid.
- iReady  in  1  downstream accepts when oValid&iReady.
- oDone  out  1  one-cycle pulse after last path transferred.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, path RAM contents don't-care, LFSR = SEED. Reset mid-operation aborts the run immediately; no oDone is produced.
- Input capture: iMu, iSigma, iS and iSteps are captured on the accepted start. Later input changes have no effect until the next run.
- FSM IDLE: on iStart go to LOAD, set oBusy. iStart in any other state is ignored.
- FSM LOAD: NPATHS cycles, writing captured S0 into each path slot. Then go to RUN, or to DRAIN if iSteps==0.
- FSM RUN: exactly one path-step per cycle, path index 0..NPATHS-1, then step+1. Leaves after iSteps·NPATHS cycles, going to DRAIN.
- FSM DRAIN: presents paths 0..NPATHS-1 in order, with oValid high.
  - oS/oPath are held stable while oValid & !iReady.
  - Index advances on each transfer.
  - After the last transfer: oValid=0, oBusy=0, oDone=1 for one cycle, go to IDLE.
- LFSR: 32-bit Galois, right shift. lsb=r[0]; r=r>>1; if lsb then r^=32'h8020_0003. Advances once per RUN cycle only.
- Z (signed, computed from pre-advance state r):
  - sum = r[11:0]+r[23:12]+r[31:20]+{r[7:0],r[31:28]};
  - Z = ((sum − 8190)·7) <<< (FRAC−14);
  - approx N(0,1) in Q.FRAC.
- Arithmetic, full-precision signed intermediates, arithmetic right shifts (floor):
  - inc = mu + ((sigma·Z) >>> FRAC);
  - Snext = S + ((S·inc) >>> FRAC).
- Saturation: Snext is saturated to [0, 2^W−1] before write-back. A path at 0 stays 0.
- Latency:
  - first oValid at cycle 1 + NPATHS + iSteps·NPATHS after the start edge;
  - the datapath may be pipelined internally but must preserve this count and per-path sequential correctness.

Test Plan:
- Deterministic drift: NPATHS=4, iMu=184, iSigma=0, iS=24576, iSteps=1 -> oS=24852 for paths 0..3 in order, oDone once. Same with iSteps=2 -> oS=25131 on all paths.
- Zero steps: iSteps=0, iS=24576 -> four transfers of 24576 with oPath 0,1,2,3. First oValid exactly 1+NPATHS cycles after start.
- Saturation: iS=200000, iMu=16384, iSigma=0, iSteps=1 -> oS=262143. iMu=−16384 -> oS=0. iMu=−32768 -> oS=0 (floor clamp), and the path stays 0 on further steps.
- Backpressure: during DRAIN hold iReady low 5 cycles, then toggle -> oS/oPath stable while stalled, no path skipped or duplicated, oDone only after 4th transfer.
- Stochastic reproducibility: iMu=184, iSigma=3408, iS=24576, iSteps=100 run twice -> identical oS sequences, matching a bit-exact reference model of the LFSR/Z/update. iStart pulses during RUN are ignored.
- Reset mid-RUN: assert RST at step 50 -> next cycle oBusy=0, oValid=0, no oDone. A fresh start then reproduces the same results as the uninterrupted run.
